// File: rtl/ofmap_pingpong_buffer.sv
// Double-buffered ofmap store: PE columns convert and write psums into the fill bank
// while the drain bank streams bytes out filter-major, row, column in lane-wide runs.
module ofmap_pingpong_buffer #(
    parameter int NF     = 4,
    parameter int MAXDIM = 55,
    parameter int NCOL   = 7,
    parameter int LANES  = 16,
    parameter int PW     = 16,
    localparam int FW    = (NF > 1) ? $clog2(NF) : 1,
    localparam int CW    = $clog2(LANES) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load_i,
    input  logic [5:0]           cfg_dim_i,
    input  logic                 cfg_relu_i,
    input  logic [NCOL-1:0]      wr_valid_i,
    input  logic signed [PW-1:0] wr_psum_i [NCOL],
    input  logic [FW-1:0]        wr_filter_i [NCOL],
    output logic [NCOL-1:0]      wr_ready_o,
    input  logic                 row_advance_i,
    input  logic                 fill_done_i,
    output logic [7:0]           out_data_o [LANES],
    output logic [CW-1:0]        out_valid_num_o,
    input  logic [CW-1:0]        taken_num_i,
    output logic                 drain_done_o,
    output logic                 fill_bank_free_o,
    output logic                 err_o
);
    localparam int DW   = 6;
    localparam int SW   = DW + 1;
    localparam int BANK = NF * MAXDIM * MAXDIM;
    localparam int AW   = $clog2(2 * BANK);
    localparam int RBW  = $clog2(MAXDIM + 2 * NCOL + 1);
    localparam logic [AW-1:0] BANK_A = AW'(BANK);
    localparam logic [AW-1:0] MD_A   = AW'(MAXDIM);
    localparam logic signed [PW-1:0] SAT_U8 = 255;
    localparam logic signed [PW-1:0] SAT_S8 = 127;
    localparam logic signed [PW-1:0] MIN_S8 = -128;

    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_DRAINING} bank_state_e;

    bank_state_e    fill_st_q, fill_st_d, drain_st_q, drain_st_d;
    logic           fill_sel_q, fill_sel_d;
    logic [DW-1:0]  dim_q, dim_d;
    logic           relu_q, relu_d;
    logic [RBW-1:0] row_base_q, row_base_d;
    logic [FW-1:0]  rd_f_q, rd_f_d;
    logic [DW-1:0]  rd_r_q, rd_r_d, rd_c_q, rd_c_d;
    logic [CW-1:0]  valid_q, valid_d;
    logic           err_q, err_d, drain_done_q, drain_done_d;

    logic [7:0]     mem_q [2*BANK];
    logic [DW-1:0]  wptr_q [NF][MAXDIM];
    logic [7:0]     out_data_q [LANES];

    logic           fill_open, swap;
    logic [NCOL-1:0] wen, wdrop;
    logic [AW-1:0]  waddr [NCOL];
    logic [7:0]     wbyte [NCOL];
    logic [DW-1:0]  wrow [NCOL];
    logic [CW-1:0]  take;
    logic [SW-1:0]  csum;
    logic [DW-1:0]  rem;
    logic [AW-1:0]  rd_base_d;

    function automatic logic [7:0] conv(input logic signed [PW-1:0] v, input logic relu);
        if (relu) begin
            if (v < 0)           return 8'h00;
            else if (v > SAT_U8) return 8'hFF;
            else                 return v[7:0];
        end
        if (v < MIN_S8)      return 8'h80;
        else if (v > SAT_S8) return 8'h7F;
        else                 return v[7:0];
    endfunction

    assign fill_open = (fill_st_q == ST_EMPTY) || (fill_st_q == ST_FILLING);
    assign swap      = (fill_st_q == ST_FULL) && (drain_st_q == ST_EMPTY);

    // Column gi always writes row row_base+gi; each (filter,row) keeps its own column pointer.
    for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
        logic [RBW-1:0] row;
        logic [DW-1:0]  ptr;
        assign row            = row_base_q + RBW'(gi);
        assign wrow[gi]       = row[DW-1:0];
        assign wr_ready_o[gi] = fill_open && (row < RBW'(dim_q));
        assign ptr            = wptr_q[wr_filter_i[gi]][row[DW-1:0]];
        assign wen[gi]        = wr_valid_i[gi] && wr_ready_o[gi] && (ptr != dim_q);
        assign wdrop[gi]      = wr_valid_i[gi] && wr_ready_o[gi] && (ptr == dim_q);
        assign waddr[gi]      = (fill_sel_q ? BANK_A : '0)
                              + (AW'(wr_filter_i[gi]) * MD_A + AW'(row[DW-1:0])) * MD_A + AW'(ptr);
        assign wbyte[gi]      = conv(wr_psum_i[gi], relu_q);
    end

    always_comb begin
        fill_st_d    = fill_st_q;
        drain_st_d   = drain_st_q;
        fill_sel_d   = fill_sel_q;
        dim_d        = dim_q;
        relu_d       = relu_q;
        row_base_d   = row_base_q;
        rd_f_d       = rd_f_q;
        rd_r_d       = rd_r_q;
        rd_c_d       = rd_c_q;
        err_d        = err_q;
        drain_done_d = 1'b0;
        take         = taken_num_i;
        csum         = SW'(rd_c_q) + SW'(taken_num_i);

        if (taken_num_i > valid_q) begin
            take  = '0;
            csum  = SW'(rd_c_q);
            err_d = 1'b1;
        end
        if (|wdrop) err_d = 1'b1;
        if (cfg_load_i) begin
            if (fill_st_q == ST_EMPTY && drain_st_q == ST_EMPTY) begin
                dim_d  = cfg_dim_i;
                relu_d = cfg_relu_i;
            end else begin
                err_d = 1'b1;
            end
        end
        if ((|(wen | wdrop)) && fill_st_q == ST_EMPTY) fill_st_d = ST_FILLING;
        if (row_advance_i && fill_open && row_base_q < RBW'(dim_q))
            row_base_d = row_base_q + RBW'(NCOL);
        if (fill_done_i) begin
            row_base_d = '0;
            if (fill_open) fill_st_d = ST_FULL;
        end
        if (swap) begin
            fill_st_d  = ST_EMPTY;
            drain_st_d = ST_DRAINING;
            fill_sel_d = ~fill_sel_q;
            row_base_d = '0;
            rd_f_d     = '0;
            rd_r_d     = '0;
            rd_c_d     = '0;
        end
        // A run never crosses a row, so the column sum lands exactly on D at row end.
        if (drain_st_q == ST_DRAINING && take != '0) begin
            if (csum == SW'(dim_q)) begin
                rd_c_d = '0;
                if (rd_r_q == dim_q - DW'(1)) begin
                    rd_r_d = '0;
                    if (rd_f_q == FW'(NF - 1)) begin
                        rd_f_d       = '0;
                        drain_st_d   = ST_EMPTY;
                        drain_done_d = 1'b1;
                    end else begin
                        rd_f_d = rd_f_q + FW'(1);
                    end
                end else begin
                    rd_r_d = rd_r_q + DW'(1);
                end
            end else begin
                rd_c_d = csum[DW-1:0];
            end
        end

        rem     = dim_q - rd_c_d;
        valid_d = '0;
        if (drain_st_d == ST_DRAINING)
            valid_d = (SW'(rem) > SW'(LANES)) ? CW'(LANES) : CW'(rem);
        rd_base_d = (fill_sel_d ? '0 : BANK_A)
                  + (AW'(rd_f_d) * MD_A + AW'(rd_r_d)) * MD_A + AW'(rd_c_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_st_q    <= ST_EMPTY;
            drain_st_q   <= ST_EMPTY;
            fill_sel_q   <= 1'b0;
            dim_q        <= DW'(MAXDIM);
            relu_q       <= 1'b1;
            row_base_q   <= '0;
            rd_f_q       <= '0;
            rd_r_q       <= '0;
            rd_c_q       <= '0;
            valid_q      <= '0;
            err_q        <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            fill_st_q    <= fill_st_d;
            drain_st_q   <= drain_st_d;
            fill_sel_q   <= fill_sel_d;
            dim_q        <= dim_d;
            relu_q       <= relu_d;
            row_base_q   <= row_base_d;
            rd_f_q       <= rd_f_d;
            rd_r_q       <= rd_r_d;
            rd_c_q       <= rd_c_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            drain_done_q <= drain_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || swap) begin
            for (int f = 0; f < NF; f++)
                for (int r = 0; r < MAXDIM; r++)
                    wptr_q[f][r] <= '0;
        end else begin
            for (int i = 0; i < NCOL; i++)
                if (wen[i]) wptr_q[wr_filter_i[i]][wrow[i]] <= wptr_q[wr_filter_i[i]][wrow[i]] + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOL; i++)
            if (wen[i]) mem_q[waddr[i]] <= wbyte[i];
    end

    // Output lanes are fetched from the next-state pointer so they line up with it after the edge.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (!rst_n)                    out_data_q[gi] <= '0;
            else if (CW'(gi) < valid_d)    out_data_q[gi] <= mem_q[rd_base_d + AW'(gi)];
            else                           out_data_q[gi] <= '0;
        end
        assign out_data_o[gi] = out_data_q[gi];
    end

    assign out_valid_num_o  = valid_q;
    assign drain_done_o     = drain_done_q;
    assign fill_bank_free_o = (fill_st_q == ST_EMPTY);
    assign err_o            = err_q;
endmodule
